// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file of the MIPS pipeline.
// Two combinational read ports with write-first bypass, plus a commit counter.
module wb_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    WB_Rd,
  input  logic [DW-1:0] WB_ALUOut,
  input  logic [DW-1:0] WB_Read_Data,
  input  logic          WB_MemtoReg,
  input  logic          WB_RegWrite,
  input  logic [4:0]    ID_Rs,
  input  logic [4:0]    ID_Rt,
  output logic [DW-1:0] ID_ReadData1,
  output logic [DW-1:0] ID_ReadData2,
  output logic [DW-1:0] WB_WriteData,
  output logic          WB_WriteValid,
  output logic [31:0]   WB_CommitCount
);

  logic [DW-1:0] regs [NREG];
  logic [31:0]   commit_count;

  assign WB_WriteData   = WB_MemtoReg ? WB_Read_Data : WB_ALUOut;
  assign WB_WriteValid  = WB_RegWrite && (WB_Rd != 5'd0);
  assign WB_CommitCount = commit_count;

  // Register 0 is never written because WB_WriteValid excludes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
      commit_count <= '0;
    end else if (WB_WriteValid) begin
      regs[WB_Rd]  <= WB_WriteData;
      commit_count <= commit_count + 32'd1;
    end
  end

  // Write-first bypass so ID sees a value committed on this same edge.
  always_comb begin
    ID_ReadData1 = regs[ID_Rs];
    if (ID_Rs == 5'd0) begin
      ID_ReadData1 = '0;
    end else if (WB_WriteValid && (WB_Rd == ID_Rs)) begin
      ID_ReadData1 = WB_WriteData;
    end
  end

  always_comb begin
    ID_ReadData2 = regs[ID_Rt];
    if (ID_Rt == 5'd0) begin
      ID_ReadData2 = '0;
    end else if (WB_WriteValid && (WB_Rd == ID_Rt)) begin
      ID_ReadData2 = WB_WriteData;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile; stimulus pushes expected outputs into a
// queue that a separate monitor pops and compares on each falling clock edge.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic [4:0]  WB_Rd;
  logic [31:0] WB_ALUOut;
  logic [31:0] WB_Read_Data;
  logic        WB_MemtoReg;
  logic        WB_RegWrite;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] WB_WriteData;
  logic        WB_WriteValid;
  logic [31:0] WB_CommitCount;

  wb_regfile #(.NREG(32), .DW(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .WB_Rd          (WB_Rd),
    .WB_ALUOut      (WB_ALUOut),
    .WB_Read_Data   (WB_Read_Data),
    .WB_MemtoReg    (WB_MemtoReg),
    .WB_RegWrite    (WB_RegWrite),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_ReadData1   (ID_ReadData1),
    .ID_ReadData2   (ID_ReadData2),
    .WB_WriteData   (WB_WriteData),
    .WB_WriteValid  (WB_WriteValid),
    .WB_CommitCount (WB_CommitCount)
  );

  typedef struct {
    logic        rst;
    logic        preload;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic        m2r;
    logic        rw;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_wd;
    logic        e_wv;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    if (v.preload) begin
      force dut.commit_count = 32'hFFFF_FFFF;
      #1;
      release dut.commit_count;
    end
    reset        = v.rst;
    WB_Rd        = v.rd;
    WB_ALUOut    = v.alu;
    WB_Read_Data = v.mem;
    WB_MemtoReg  = v.m2r;
    WB_RegWrite  = v.rw;
    ID_Rs        = v.rs;
    ID_Rt        = v.rt;
    expq.push_back(v);
  endtask

  task automatic addVec(input logic rst, input logic pre, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem,
                        input logic m2r, input logic rw, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [31:0] ewd,
                        input logic ewv, input logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.preload = pre; v.rd = rd; v.alu = alu; v.mem = mem;
    v.m2r = m2r; v.rw = rw; v.rs = rs; v.rt = rt;
    v.e_rd1 = e1; v.e_rd2 = e2; v.e_wd = ewd; v.e_wv = ewv; v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  // Monitor: the combinational outputs are settled by the falling edge.
  initial begin : monitor
    int idx = 0;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        vec_t e;
        e = expq.pop_front();
        checkOutput("ReadData1",   idx, ID_ReadData1,          e.e_rd1);
        checkOutput("ReadData2",   idx, ID_ReadData2,          e.e_rd2);
        checkOutput("WriteData",   idx, WB_WriteData,          e.e_wd);
        checkOutput("WriteValid",  idx, {31'd0, WB_WriteValid}, {31'd0, e.e_wv});
        checkOutput("CommitCount", idx, WB_CommitCount,        e.e_cnt);
        idx++;
      end
    end
  end

  initial begin : driver
    int budget;
    reset = 1'b0; WB_Rd = '0; WB_ALUOut = '0; WB_Read_Data = '0;
    WB_MemtoReg = 1'b0; WB_RegWrite = 1'b0; ID_Rs = '0; ID_Rt = '0;

    //     rst pre rd  alu           mem           m2r rw rs  rt  rd1           rd2           wd            wv cnt
    addVec(0, 0, 0,  32'h0,        32'h0,        0, 0, 0,  0,  32'h0,        32'h0,        32'h0,        0, 32'd0);
    addVec(1, 0, 8,  32'hDEADBEEF, 32'h0,        0, 1, 8,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1, 32'd0);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 8,  8,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        0, 32'd1);
    addVec(1, 0, 9,  32'h11111111, 32'h0000CAFE, 1, 1, 9,  9,  32'h0000CAFE, 32'h0000CAFE, 32'h0000CAFE, 1, 32'd1);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 9,  8,  32'h0000CAFE, 32'hDEADBEEF, 32'h0,        0, 32'd2);
    addVec(1, 0, 0,  32'hFFFFFFFF, 32'h0,        0, 1, 0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 0, 32'd2);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 0,  9,  32'h0,        32'h0000CAFE, 32'h0,        0, 32'd2);
    addVec(1, 0, 10, 32'h55,       32'h0,        0, 0, 0,  10, 32'h0,        32'h0,        32'h55,       0, 32'd2);
    addVec(1, 0, 10, 32'h55,       32'h0,        0, 0, 0,  10, 32'h0,        32'h0,        32'h55,       0, 32'd2);
    addVec(1, 0, 10, 32'h55,       32'h0,        0, 0, 0,  10, 32'h0,        32'h0,        32'h55,       0, 32'd2);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 10, 10, 32'h0,        32'h0,        32'h0,        0, 32'd2);
    addVec(1, 0, 5,  32'h1234,     32'h0,        0, 1, 5,  0,  32'h1234,     32'h0,        32'h1234,     1, 32'd2);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 5,  8,  32'h1234,     32'hDEADBEEF, 32'h0,        0, 32'd3);
    // Mid-run reset with a write on the same edge: file cleared, write dropped.
    addVec(0, 0, 6,  32'h77,       32'h0,        0, 1, 5,  8,  32'h0,        32'h0,        32'h77,       1, 32'd0);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 6,  5,  32'h0,        32'h0,        32'h0,        0, 32'd0);
    addVec(1, 0, 7,  32'hABCD,     32'h0,        0, 1, 7,  6,  32'hABCD,     32'h0,        32'hABCD,     1, 32'd0);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 7,  0,  32'hABCD,     32'h0,        32'h0,        0, 32'd1);
    // Counter preloaded to all-ones, then one commit wraps it to zero.
    addVec(1, 1, 11, 32'h1,        32'h0,        0, 1, 0,  0,  32'h0,        32'h0,        32'h1,        1, 32'hFFFFFFFF);
    addVec(1, 0, 0,  32'h0,        32'h0,        0, 0, 11, 7,  32'h1,        32'hABCD,     32'h0,        0, 32'd0);

    repeat (2) @(posedge clk);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    budget = 20;
    while (expq.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (expq.size() > 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expq.size());
    end
    stim_done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #100000;
    if (!stim_done) begin
      $display("[TB] FAIL timeout: stimulus incomplete, expected completion");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
